// File: rtl/ltl_mon_pkg.sv
// Shared types and constants for the LTL monitor hub.
// States of the first-violation capture FSM plus alignment limits.
package ltl_mon_pkg;

    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CAPTURED = 2'd1,
        CLEAR    = 2'd2
    } mon_state_t;

    localparam int MAX_AUTO_LAT = 7;
    localparam int TS_W         = 32;

endpackage

// File: rtl/ltl_mon_delay.sv
// Width/depth parametrised shift register with synchronous reset.
// DEPTH of 0 degenerates to a straight wire.
module ltl_mon_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_line
        logic [W-1:0] stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/ltl_monitor_hub.sv
// LTL monitor hub: symbol forwarding, tap alignment, sticky flags, counters, capture.
// Optional LTL_MON_TIMESTAMP_EN adds a free-running cycle counter and first_ts.
module ltl_monitor_hub
    import ltl_mon_pkg::*;
#(
    parameter int NUM_PROPS = 4,
    parameter int NUM_TAPS  = 4,
    parameter int SYM_W     = 8,
    parameter int AUTO_LAT  = 1,
    parameter int CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic [SYM_W-1:0]                symbols,
    output logic                            auto_run,
    output logic [SYM_W-1:0]                auto_symbols,
    input  logic [NUM_PROPS*NUM_TAPS-1:0]   auto_hits,
    output logic [NUM_PROPS-1:0]            viol,
    output logic [NUM_PROPS-1:0]            sticky,
    output logic                            viol_any,
    input  logic [$clog2(NUM_PROPS)-1:0]    cnt_sel,
    output logic [CNT_W-1:0]                cnt_rdata,
    output logic                            first_valid,
    output logic [$clog2(NUM_PROPS)-1:0]    first_prop,
    output logic [SYM_W-1:0]                first_sym,
    output logic                            first_multi,
    output logic                            irq,
    input  logic                            clr_req,
    output logic                            clr_ack
`ifdef LTL_MON_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]                 first_ts
`endif
);

    localparam int SEL_W = $clog2(NUM_PROPS);
    localparam int LAT   = (AUTO_LAT > MAX_AUTO_LAT) ? MAX_AUTO_LAT : AUTO_LAT;

    mon_state_t           state_q, state_d;
    logic                 run_al;
    logic [SYM_W-1:0]     sym_al;
    logic [NUM_PROPS-1:0] hit;
    logic [SEL_W-1:0]     lo_idx;
    logic                 capture, in_clear;
    logic [CNT_W-1:0]     cnt_q [NUM_PROPS];

    always_ff @(posedge clk) begin
        if (reset) begin
            auto_run     <= 1'b0;
            auto_symbols <= '0;
        end else begin
            auto_run     <= run;
            auto_symbols <= symbols;
        end
    end

    ltl_mon_delay #(
        .W     (SYM_W + 1),
        .DEPTH (LAT)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({auto_run, auto_symbols}),
        .dout  ({run_al, sym_al})
    );

    always_comb begin
        hit = '0;
        for (int p = 0; p < NUM_PROPS; p++)
            hit[p] = run_al & (|auto_hits[p*NUM_TAPS +: NUM_TAPS]);
    end

    // Scan downward so the lowest hitting index wins.
    always_comb begin
        lo_idx = '0;
        for (int p = NUM_PROPS - 1; p >= 0; p--)
            if (hit[p]) lo_idx = SEL_W'(p);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ARMED;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARMED: begin
                if (clr_req)   state_d = CLEAR;
                else if (|hit) state_d = CAPTURED;
            end
            CAPTURED: if (clr_req) state_d = CLEAR;
            CLEAR:    state_d = ARMED;
            default:  state_d = ARMED;
        endcase
    end

    always_comb begin
        in_clear = (state_q == CLEAR);
        capture  = (state_q == ARMED) && (|hit);
        clr_ack  = in_clear;
    end

    always_ff @(posedge clk) begin
        if (reset) viol <= '0;
        else       viol <= hit;
    end

    always_ff @(posedge clk) begin
        if (reset || in_clear) begin
            for (int p = 0; p < NUM_PROPS; p++) cnt_q[p] <= '0;
            sticky      <= '0;
            first_valid <= 1'b0;
            first_prop  <= '0;
            first_sym   <= '0;
            first_multi <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PROPS; p++)
                if (hit[p] && (cnt_q[p] != '1))
                    cnt_q[p] <= cnt_q[p] + CNT_W'(1);
            sticky <= sticky | hit;
            if (capture) begin
                first_valid <= 1'b1;
                first_prop  <= lo_idx;
                first_sym   <= sym_al;
                first_multi <= |(hit & (hit - NUM_PROPS'(1)));
            end
        end
    end

`ifdef LTL_MON_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || in_clear) first_ts <= '0;
        else if (capture)      first_ts <= ts_q;
    end
`endif

    assign viol_any  = |viol;
    assign irq       = first_valid;
    assign cnt_rdata = cnt_q[cnt_sel];

endmodule

// File: tb/tb_ltl_monitor_hub.sv
// Randomised and directed bench for ltl_monitor_hub.
// Reference model tracks aligned symbols with a latency queue.
module tb_ltl_monitor_hub;

    localparam int NP  = 4;
    localparam int NT  = 4;
    localparam int SW  = 8;
    localparam int LAT = 1;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            reset, run, clr_req;
    logic [SW-1:0]   symbols;
    logic            auto_run;
    logic [SW-1:0]   auto_symbols;
    logic [NP*NT-1:0] auto_hits;
    logic [NP-1:0]   viol, sticky;
    logic            viol_any;
    logic [1:0]      cnt_sel;
    logic [CW-1:0]   cnt_rdata;
    logic            first_valid;
    logic [1:0]      first_prop;
    logic [SW-1:0]   first_sym;
    logic            first_multi, irq, clr_ack;
`ifdef LTL_MON_TIMESTAMP_EN
    logic [31:0]     first_ts;
`endif

    ltl_monitor_hub #(
        .NUM_PROPS (NP),
        .NUM_TAPS  (NT),
        .SYM_W     (SW),
        .AUTO_LAT  (LAT),
        .CNT_W     (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .symbols      (symbols),
        .auto_run     (auto_run),
        .auto_symbols (auto_symbols),
        .auto_hits    (auto_hits),
        .viol         (viol),
        .sticky       (sticky),
        .viol_any     (viol_any),
        .cnt_sel      (cnt_sel),
        .cnt_rdata    (cnt_rdata),
        .first_valid  (first_valid),
        .first_prop   (first_prop),
        .first_sym    (first_sym),
        .first_multi  (first_multi),
        .irq          (irq),
        .clr_req      (clr_req),
        .clr_ack      (clr_ack)
`ifdef LTL_MON_TIMESTAMP_EN
        ,
        .first_ts     (first_ts)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    logic [SW:0]   q[$];
    int            cnt_m [NP];
    logic [NP-1:0] viol_m, sticky_m;
    logic          fv_m, fm_m, clr_m;
    int            fp_m;
    logic [SW-1:0] fs_m;
    int unsigned   ts_m, fts_m;

    task automatic model_zero();
        for (int p = 0; p < NP; p++) cnt_m[p] = 0;
        sticky_m = '0;
        fv_m = 1'b0;
        fm_m = 1'b0;
        fp_m = 0;
        fs_m = '0;
        fts_m = 0;
    endtask

    // One clock edge: the model consumes the inputs seen at the edge.
    task automatic step();
        logic [SW:0]   al;
        logic [NP-1:0] h;
        @(posedge clk);
        if (reset) begin
            q = {};
            for (int i = 0; i <= LAT; i++) q.push_back('0);
            model_zero();
            viol_m = '0;
            clr_m = 1'b0;
            ts_m = 0;
        end else begin
            al = q.pop_front();
            q.push_back({run, symbols});
            h = '0;
            for (int p = 0; p < NP; p++)
                h[p] = al[SW] && (auto_hits[p*NT +: NT] != '0);
            viol_m = h;
            if (clr_m) begin
                model_zero();
                clr_m = 1'b0;
            end else begin
                for (int p = 0; p < NP; p++)
                    if (h[p] && cnt_m[p] < MAXC) cnt_m[p]++;
                sticky_m |= h;
                if (!fv_m && h != '0) begin
                    fv_m = 1'b1;
                    fs_m = al[SW-1:0];
                    fm_m = ($countones(h) > 1);
                    fts_m = ts_m;
                    for (int p = NP - 1; p >= 0; p--)
                        if (h[p]) fp_m = p;
                end
                if (clr_req) clr_m = 1'b1;
            end
            ts_m++;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        run = 1'b0;
        symbols = '0;
        auto_hits = '0;
        clr_req = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        run = 1'b1;
        symbols = 8'hC3;
        auto_hits = '1;
        clr_req = 1'b1;
        step();
        step();
        step();
        idle_inputs();
        reset = 1'b0;
        total++;
        if ({viol, sticky, viol_any, first_valid, irq, clr_ack} !== '0)
            $display("FAIL reset_flags got %b/%b %b%b%b%b want 0",
                     viol, sticky, viol_any, first_valid, irq, clr_ack);
        else passed++;
        total++;
        if ({first_prop, first_sym, first_multi, auto_run, auto_symbols} !== '0)
            $display("FAIL reset_first got %h %h %b %b %h want 0",
                     first_prop, first_sym, first_multi, auto_run, auto_symbols);
        else passed++;
        for (int p = 0; p < NP; p++) begin
            cnt_sel = 2'(p);
            #1;
            total++;
            if (cnt_rdata !== '0)
                $display("FAIL reset_cnt%0d got %0d want 0", p, cnt_rdata);
            else passed++;
        end
    endtask

    task automatic test_single_prop();
        apply_reset();
        run = 1'b1;
        symbols = 8'h5A;
        step();
        total++;
        if (auto_run !== 1'b1 || auto_symbols !== 8'h5A)
            $display("FAIL fwd got %b %h want 1 5a", auto_run, auto_symbols);
        else passed++;
        run = 1'b0;
        symbols = '0;
        step();
        total++;
        if (viol !== '0) $display("FAIL single_early got %b want 0000", viol);
        else passed++;
        auto_hits = 16'h0100;
        step();
        auto_hits = '0;
        total++;
        if (viol !== 4'b0100 || sticky !== 4'b0100 || viol_any !== 1'b1)
            $display("FAIL single_viol got %b %b %b want 0100 0100 1",
                     viol, sticky, viol_any);
        else passed++;
        total++;
        if (first_prop !== 2'd2 || first_sym !== 8'h5A || irq !== 1'b1 || first_multi !== 1'b0)
            $display("FAIL single_first got %0d %h %b %b want 2 5a 1 0",
                     first_prop, first_sym, irq, first_multi);
        else passed++;
        cnt_sel = 2'd2;
        #1;
        total++;
        if (cnt_rdata !== 4'd1) $display("FAIL single_cnt got %0d want 1", cnt_rdata);
        else passed++;
        step();
        total++;
        if (viol !== '0 || sticky !== 4'b0100)
            $display("FAIL single_pulse got %b %b want 0000 0100", viol, sticky);
        else passed++;
    endtask

    task automatic test_multi();
        apply_reset();
        run = 1'b1;
        symbols = 8'h33;
        step();
        run = 1'b0;
        symbols = '0;
        step();
        auto_hits = 16'h2040;
        step();
        auto_hits = '0;
        total++;
        if (first_prop !== 2'd1 || first_multi !== 1'b1 || first_sym !== 8'h33)
            $display("FAIL multi_first got %0d %b %h want 1 1 33",
                     first_prop, first_multi, first_sym);
        else passed++;
        for (int p = 0; p < NP; p++) begin
            cnt_sel = 2'(p);
            #1;
            total++;
            if (cnt_rdata !== ((p == 1 || p == 3) ? 4'd1 : 4'd0))
                $display("FAIL multi_cnt%0d got %0d want %0d", p, cnt_rdata,
                         (p == 1 || p == 3) ? 1 : 0);
            else passed++;
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        run = 1'b1;
        auto_hits = 16'h0001;
        cnt_sel = 2'd0;
        for (int i = 1; i <= 21; i++) begin
            symbols = 8'(i);
            step();
            if (i == 10) begin
                #1;
                total++;
                if (cnt_rdata !== 4'd8) $display("FAIL sat_mid got %0d want 8", cnt_rdata);
                else passed++;
            end
        end
        #1;
        total++;
        if (cnt_rdata !== 4'd15) $display("FAIL sat_top got %0d want 15", cnt_rdata);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_clear();
        apply_reset();
        run = 1'b1;
        step();
        step();
        auto_hits = 16'h0001;
        clr_req = 1'b1;
        step();
        cnt_sel = 2'd0;
        #1;
        total++;
        if (clr_ack !== 1'b1 || cnt_rdata !== 4'd1 || first_valid !== 1'b1 || sticky !== 4'b0001)
            $display("FAIL clr_enter got ack%b cnt%0d fv%b st%b want 1 1 1 0001",
                     clr_ack, cnt_rdata, first_valid, sticky);
        else passed++;
        clr_req = 1'b0;
        step();
        #1;
        total++;
        if (clr_ack !== 1'b0 || cnt_rdata !== 4'd0 || first_valid !== 1'b0 || sticky !== '0)
            $display("FAIL clr_done got ack%b cnt%0d fv%b st%b want 0 0 0 0000",
                     clr_ack, cnt_rdata, first_valid, sticky);
        else passed++;
        total++;
        if (viol !== 4'b0001) $display("FAIL clr_viol got %b want 0001", viol);
        else passed++;
        auto_hits = '0;
        step();
        #1;
        total++;
        if (cnt_rdata !== 4'd0 || first_valid !== 1'b0 || irq !== 1'b0)
            $display("FAIL clr_drop got cnt%0d fv%b irq%b want 0 0 0",
                     cnt_rdata, first_valid, irq);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_run_gate();
        apply_reset();
        run = 1'b0;
        auto_hits = '1;
        for (int i = 0; i < 4; i++) begin
            symbols = 8'($urandom);
            step();
        end
        auto_hits = '0;
        total++;
        if (viol !== '0 || sticky !== '0 || first_valid !== 1'b0)
            $display("FAIL gate got %b %b %b want 0000 0000 0", viol, sticky, first_valid);
        else passed++;
        for (int p = 0; p < NP; p++) begin
            cnt_sel = 2'(p);
            #1;
            total++;
            if (cnt_rdata !== '0) $display("FAIL gate_cnt%0d got %0d want 0", p, cnt_rdata);
            else passed++;
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            run = ($urandom_range(0, 3) != 0);
            symbols = 8'($urandom);
            for (int b = 0; b < NP*NT; b++) auto_hits[b] = ($urandom_range(0, 15) == 0);
            clr_req = ($urandom_range(0, 19) == 0);
            step();
            total++;
            if (viol !== viol_m || sticky !== sticky_m || viol_any !== (viol_m != '0))
                $display("FAIL rnd_flags c%0d got %b %b %b want %b %b %b", c,
                         viol, sticky, viol_any, viol_m, sticky_m, viol_m != '0);
            else passed++;
            total++;
            if (first_valid !== fv_m || irq !== fv_m || first_prop !== 2'(fp_m) ||
                first_sym !== fs_m || first_multi !== fm_m)
                $display("FAIL rnd_first c%0d got %b %b %0d %h %b want %b %0d %h %b", c,
                         first_valid, irq, first_prop, first_sym, first_multi,
                         fv_m, fp_m, fs_m, fm_m);
            else passed++;
            total++;
            if (clr_ack !== clr_m || auto_run !== q[$][SW] || auto_symbols !== q[$][SW-1:0])
                $display("FAIL rnd_fwd c%0d got %b %b %h want %b %b %h", c,
                         clr_ack, auto_run, auto_symbols, clr_m, q[$][SW], q[$][SW-1:0]);
            else passed++;
            for (int p = 0; p < NP; p++) begin
                cnt_sel = 2'(p);
                #1;
                total++;
                if (cnt_rdata !== CW'(cnt_m[p]))
                    $display("FAIL rnd_cnt%0d c%0d got %0d want %0d", p, c, cnt_rdata, cnt_m[p]);
                else passed++;
            end
        end
        reset = 1'b0;
        idle_inputs();
    endtask

`ifdef LTL_MON_TIMESTAMP_EN
    task automatic test_timestamp();
        apply_reset();
        run = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            auto_hits = (i == 100) ? 16'h0010 : 16'h0000;
            step();
        end
        idle_inputs();
        total++;
        if (first_ts !== 32'd99 || first_ts !== fts_m || first_valid !== 1'b1)
            $display("FAIL ts got %0d fv%b want 99 1", first_ts, first_valid);
        else passed++;
    endtask
`endif

    initial begin
        reset = 1'b1;
        cnt_sel = '0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_single_prop();
        test_multi();
        test_saturation();
        test_clear();
        test_run_gate();
`ifdef LTL_MON_TIMESTAMP_EN
        test_timestamp();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ltl_monitor_hub.md
Name: ltl_monitor_hub

Overview:
- Parametrised successor to the per-instruction-pair LTL monitor tops (e.g. the lw/lw monitor). Those tops only OR automata report taps into per-property flags.
- This hub sits between the core's symbol stream and one generated automata stage with NUM_PROPS properties and NUM_TAPS report taps per property.
- It registers and forwards symbols to the automata, aligns the report taps with the symbol that caused them, and adds per-property sticky flags, saturating violation counters, first-violation capture, an interrupt, and a clear handshake.

Parameters:
- NUM_PROPS, 4, number of LTL properties monitored.
- NUM_TAPS, 4, report-state taps per property that are OR-reduced.
- SYM_W, 8, symbol width.
- AUTO_LAT, 1, cycles from auto_symbols to auto_hits; legal range 0..7.
- CNT_W, 16, width of each violation counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- run  in  1  symbol valid / monitor enable
- symbols  in  SYM_W  event symbol from the core
- auto_run  out  1  registered run, driven to the automata stage
- auto_symbols  out  SYM_W  registered symbols, driven to the automata stage
- auto_hits  in  NUM_PROPS*NUM_TAPS  automata report taps; property p occupies bits [p*NUM_TAPS +: NUM_TAPS]
- viol  out  NUM_PROPS  per-property violation pulse, registered
- sticky  out  NUM_PROPS  per-property sticky violation flag
- viol_any  out  1  OR of viol
- cnt_sel  in  $clog2(NUM_PROPS)  counter read select
- cnt_rdata  out  CNT_W  counter[cnt_sel], combinational read
- first_valid  out  1  first violation has been captured
- first_prop  out  $clog2(NUM_PROPS)  property index of the first violation
- first_sym  out  SYM_W  symbol that caused the first violation
- first_multi  out  1  more than one property fired in the first-violation cycle
- irq  out  1  level interrupt; equals first_valid
- clr_req  in  1  clear request
- clr_ack  out  1  one-cycle clear acknowledge

Behaviour:
- Reset: all outputs and all state are 0; FSM = ARMED.
- auto_symbols and auto_run are symbols and run delayed by 1 cycle.
- Alignment: a delay line of depth AUTO_LAT carries auto_symbols and auto_run. This gives sym_al and run_al, aligned with auto_hits.
- hit[p] = run_al & OR(taps of p).
- viol[p] is registered from hit[p], so it rises 2+AUTO_LAT cycles after the symbol is presented.
- Counters: counter[p] increments by 1 on hit[p] and saturates at 2^CNT_W-1 (no wrap).
- sticky[p] is set on hit[p].
- While run_al=0, hits are ignored. The delay line keeps shifting.
- FSM states and transitions:
  - ARMED: any hit -> CAPTURED. On that transition, latch first_prop = lowest-index hitting p, first_sym = sym_al, first_multi = (popcount(hit) > 1), and set first_valid=1.
  - CAPTURED: first_* fields are frozen. Counters and sticky flags keep updating.
  - clr_req=1 in ARMED or CAPTURED -> CLEAR.
  - CLEAR (exactly 1 cycle): clr_ack=1. At the end of the cycle, all counters, sticky, first_* and first_valid are zeroed. Hits during CLEAR are dropped (not counted, not captured). Next state is ARMED.
  - clr_req held high for several cycles produces one CLEAR per ARMED/CAPTURED cycle it is seen in. The requester must drop clr_req on clr_ack.
- Simultaneous events:
  - Hit and clr_req in the same non-CLEAR cycle: the hit is counted and captured, then erased by the following CLEAR.
- viol itself is not cleared by CLEAR. It always reflects the previous cycle's hit.
- Reset asserted mid-operation returns the block to the reset state on the next edge. Delay-line contents are discarded (zeroed).

Optional Feature:
- LTL_MON_TIMESTAMP_EN
  - Defined: adds a 32-bit free-running cycle counter (reset 0, wraps) and output first_ts[31:0]. first_ts latches the counter value at the ARMED->CAPTURED transition and is cleared in CLEAR.
  - Undefined: the counter is absent and first_ts does not exist.

Decomposition:
- Package ltl_mon_pkg holds:
  - FSM state enum {ARMED, CAPTURED, CLEAR};
  - the MAX_AUTO_LAT=7 constant;
  - the TS_W=32 constant.
- One sub-module, ltl_mon_delay (parametrised width/depth shift register with synchronous reset), used for the symbol/run alignment line.

Test Plan:
- Reset then idle, AUTO_LAT=1 -> all outputs 0, FSM ARMED, cnt_rdata 0 for every cnt_sel.
- run=1, symbols=0x5A, taps of p=2 fire aligned -> viol[2] pulses 3 cycles after the symbol; sticky[2]=1; first_prop=2, first_sym=0x5A, irq=1; counter[2]=1.
- Properties 1 and 3 hit in the same cycle while ARMED -> first_prop=1, first_multi=1; both counters = 1.
- 2^CNT_W+3 hits on p=0 with CNT_W=4 -> cnt_rdata stays at 15.
- clr_req in the same cycle as a hit on p=0 -> hit counted, then a CLEAR cycle with clr_ack=1; counters, sticky and first_valid are 0 afterwards; a hit during CLEAR is not counted.
- Hits with run_al=0 -> no viol, no count, no capture. With LTL_MON_TIMESTAMP_EN defined, a first hit at cycle 100 after reset gives the first_ts value latched at that capture edge.
